// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer for the tiny CPU.
// One clock domain; a free-running prescaler produces an enable tick that paces every state
// transition and strobe. Provides run / halt / single-step control and a retired-instruction
// counter.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        synchronous active-low reset
//   run          level: 1 = free-run, 0 = stop at next instruction boundary
//   step         one-CLK pulse: execute exactly one instruction while halted
//   rom_data     instruction at rom_addr ([7:4] opcode, [3:0] register select)
//   rom_addr     ROM address (always equal to pc)
//   pc           program counter
//   opcode       ir[7:4]
//   rf_sel       ir[3:0]
//   rf_rd_en     register read strobe (DECODE tick)
//   alu_en       ALU strobe (EXECUTE tick)
//   rf_wr_en     register write strobe (WRITEBACK tick)
//   halted       1 while in HALT
//   state        HALT=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4
//   instr_count  retired-instruction counter (wraps)
`timescale 1ns / 1ps

module cpu_sequencer #(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned PRESCALE = 1048576,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             run,
  input  logic             step,
  input  logic [7:0]       rom_data,
  output logic [PC_W-1:0]  rom_addr,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       opcode,
  output logic [3:0]       rf_sel,
  output logic             rf_rd_en,
  output logic             alu_en,
  output logic             rf_wr_en,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StHalt      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StWriteback = 3'd4
  } state_e;

  // 24 bits covers the largest legal PRESCALE (2^24 -> terminal count 2^24-1).
  localparam int unsigned PsW    = 24;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  state_e           r_state;
  logic [PsW-1:0]   r_ps;
  logic [PC_W-1:0]  r_pc;
  logic [7:0]       r_ir;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stop;
  logic             r_step_pend;
  logic             r_one_shot;

  logic       w_tick;
  logic       w_step_req;
  logic [3:0] w_op;
  logic       w_is_alu;
  logic       w_is_hlt;
  logic       w_bstop;

  assign w_tick     = (r_ps == PsLast);
  // A step arriving on the very tick it is consumed goes straight through.
  assign w_step_req = step | r_step_pend;
  assign w_op       = r_ir[7:4];
  assign w_is_alu   = (w_op >= 4'd1) && (w_op <= 4'd8);
  assign w_is_hlt   = (w_op == 4'hF);
  assign w_bstop    = !run || r_one_shot;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= StHalt;
      r_ps        <= '0;
      r_pc        <= '0;
      r_ir        <= '0;
      r_cnt       <= '0;
      r_stop      <= 1'b0;
      r_step_pend <= 1'b0;
      r_one_shot  <= 1'b0;
    end else begin
      r_ps <= w_tick ? '0 : r_ps + 1'b1;
      if (step) r_step_pend <= 1'b1;
      if (!run) r_stop <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          StHalt: begin
            if ((run && !r_stop) || w_step_req) begin
              r_state <= StFetch;
              if (w_step_req) begin
                r_step_pend <= 1'b0;
                r_one_shot  <= 1'b1;
              end
            end
          end
          StFetch: begin
            r_ir    <= rom_data;
            r_state <= StDecode;
          end
          StDecode: begin
            if (w_is_alu) begin
              r_state <= StExecute;
            end else begin
              // NOP, reserved and HLT all retire here without EXECUTE/WRITEBACK.
              r_pc       <= r_pc + 1'b1;
              r_cnt      <= r_cnt + 1'b1;
              r_one_shot <= 1'b0;
              if (w_is_hlt) begin
                r_stop  <= 1'b1;
                r_state <= StHalt;
              end else begin
                r_state <= w_bstop ? StHalt : StFetch;
              end
            end
          end
          StExecute: begin
            r_state <= StWriteback;
          end
          StWriteback: begin
            r_pc       <= r_pc + 1'b1;
            r_cnt      <= r_cnt + 1'b1;
            r_one_shot <= 1'b0;
            r_state    <= w_bstop ? StHalt : StFetch;
          end
          default: begin
            r_state <= StHalt;
          end
        endcase
      end
    end
  end

  // Strobes must coincide with the tick cycle of their state, so they are decoded from the
  // registered state rather than registered themselves; RST_N gating suppresses a strobe in a
  // cycle that is being reset.
  assign rf_rd_en = RST_N && w_tick && (r_state == StDecode);
  assign alu_en   = RST_N && w_tick && (r_state == StExecute);
  assign rf_wr_en = RST_N && w_tick && (r_state == StWriteback);

  assign rom_addr    = r_pc;
  assign pc          = r_pc;
  assign opcode      = r_ir[7:4];
  assign rf_sel      = r_ir[3:0];
  assign halted      = (r_state == StHalt);
  assign state       = r_state;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer. Two instances: PRESCALE=1 (functional tests) and PRESCALE=3
// (tick pacing and reset in the middle of WRITEBACK). Each expected write-back is queued when
// stimulus is issued; a monitor per instance pops and compares on every rf_wr_en strobe.
`timescale 1ns / 1ps

module tb_cpu_sequencer;

  typedef struct packed {
    logic [3:0]  pc;
    logic [3:0]  sel;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q1[$];
  exp_t q2[$];

  // ---------------- DUT 1: PRESCALE = 1 ----------------
  logic        rst1, run1, step1;
  logic [7:0]  rom1 [16];
  logic [7:0]  data1;
  logic [3:0]  addr1, pc1, op1, sel1;
  logic        rd1, alu1, wr1, halted1;
  logic [2:0]  st1;
  logic [15:0] cnt1;

  assign data1 = rom1[addr1];

  cpu_sequencer #(.PC_W(4), .PRESCALE(1), .CNT_W(16)) u_dut1 (
    .CLK(clk), .RST_N(rst1), .run(run1), .step(step1), .rom_data(data1),
    .rom_addr(addr1), .pc(pc1), .opcode(op1), .rf_sel(sel1), .rf_rd_en(rd1),
    .alu_en(alu1), .rf_wr_en(wr1), .halted(halted1), .state(st1), .instr_count(cnt1)
  );

  // ---------------- DUT 2: PRESCALE = 3 ----------------
  logic        rst2, run2, step2;
  logic [7:0]  rom2 [16];
  logic [7:0]  data2;
  logic [3:0]  addr2, pc2, op2, sel2;
  logic        rd2, alu2, wr2, halted2;
  logic [2:0]  st2;
  logic [15:0] cnt2;

  assign data2 = rom2[addr2];

  cpu_sequencer #(.PC_W(4), .PRESCALE(3), .CNT_W(16)) u_dut2 (
    .CLK(clk), .RST_N(rst2), .run(run2), .step(step2), .rom_data(data2),
    .rom_addr(addr2), .pc(pc2), .opcode(op2), .rf_sel(sel2), .rf_rd_en(rd2),
    .alu_en(alu2), .rf_wr_en(wr2), .halted(halted2), .state(st2), .instr_count(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected {rd, alu, wr} for a tick cycle in state s.
  function automatic logic [2:0] strobes_for(input logic [2:0] s);
    case (s)
      3'd2:    strobes_for = 3'b100;
      3'd3:    strobes_for = 3'b010;
      3'd4:    strobes_for = 3'b001;
      default: strobes_for = 3'b000;
    endcase
  endfunction

  // ---------------- Scoreboard monitors ----------------
  always @(negedge clk) begin
    if (wr1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut1_unexpected_wr: strobe at pc=%0h cnt=%0d, none expected", pc1, cnt1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_wr_pc", 32'(pc1), 32'(e.pc));
        chk("dut1_wr_sel", 32'(sel1), 32'(e.sel));
        chk("dut1_wr_cnt", 32'(cnt1), 32'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (wr2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut2_unexpected_wr: strobe at pc=%0h cnt=%0d, none expected", pc2, cnt2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_wr_pc", 32'(pc2), 32'(e.pc));
        chk("dut2_wr_sel", 32'(sel2), 32'(e.sel));
        chk("dut2_wr_cnt", 32'(cnt2), 32'(e.cnt));
      end
    end
  end

  task automatic fill_rom1(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom1[i] = v;
  endtask

  task automatic step_pulse1();
    step1 = 1'b1;
    @(negedge clk);
    step1 = 1'b0;
  endtask

  initial begin
    rst1 = 1'b0; run1 = 1'b0; step1 = 1'b0;
    rst2 = 1'b0; run2 = 1'b0; step2 = 1'b0;
    fill_rom1(8'h11);
    for (int i = 0; i < 16; i++) rom2[i] = 8'h11;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_state", 32'(st1), 0);
    chk("rst_halted", 32'(halted1), 1);
    chk("rst_pc", 32'(pc1), 0);
    chk("rst_addr", 32'(addr1), 0);
    chk("rst_ir", 32'({op1, sel1}), 0);
    chk("rst_cnt", 32'(cnt1), 0);
    chk("rst_strobes", 32'({rd1, alu1, wr1}), 0);

    // Test 1: free-run of 16 ALU ops, PRESCALE=1
    for (int i = 0; i < 16; i++) q1.push_back('{pc: 4'(i), sel: 4'd1, cnt: 16'(i)});
    run1 = 1'b1;
    rst1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] s;
      @(negedge clk);
      s = 3'(((k - 1) % 4) + 1);
      chk("t1_state", 32'(st1), 32'(s));
      chk("t1_strobes", 32'({rd1, alu1, wr1}), 32'(strobes_for(s)));
      if (k == 5) chk("t1_pc_after_wb", 32'(pc1), 1);
    end
    repeat (57) @(negedge clk);
    chk("t1_cnt16", 32'(cnt1), 16);
    chk("t1_pc_wrap", 32'(pc1), 0);
    chk("t1_state_fetch", 32'(st1), 1);
    q1.push_back('{pc: 4'd0, sel: 4'd1, cnt: 16'd16});
    run1 = 1'b0;
    repeat (8) @(negedge clk);
    chk("t1_stop_halted", 32'(halted1), 1);
    chk("t1_stop_pc", 32'(pc1), 1);
    chk("t1_stop_cnt", 32'(cnt1), 17);

    // Test 2: HLT at pc 2, then resume
    rst1 = 1'b0;
    fill_rom1(8'h12);
    rom1[2] = 8'hF0;
    q1.push_back('{pc: 4'd0, sel: 4'd2, cnt: 16'd0});
    q1.push_back('{pc: 4'd1, sel: 4'd2, cnt: 16'd1});
    repeat (2) @(negedge clk);
    run1 = 1'b1;
    rst1 = 1'b1;
    repeat (20) @(negedge clk);
    chk("t2_hlt_halted", 32'(halted1), 1);
    chk("t2_hlt_pc", 32'(pc1), 3);
    chk("t2_hlt_cnt", 32'(cnt1), 3);
    chk("t2_hlt_opcode", 32'(op1), 32'hF);
    run1 = 1'b0;
    @(negedge clk);
    q1.push_back('{pc: 4'd3, sel: 4'd2, cnt: 16'd3});
    run1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (halted1 == 1'b0) break;
    end
    chk("t2_resumed", 32'(halted1), 0);
    run1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_resume_pc", 32'(pc1), 4);
    chk("t2_resume_cnt", 32'(cnt1), 4);
    chk("t2_resume_halted", 32'(halted1), 1);

    // Test 3: single step, including a step received mid-instruction
    rst1 = 1'b0;
    fill_rom1(8'h13);
    repeat (2) @(negedge clk);
    rst1 = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_idle_halted", 32'(halted1), 1);
    chk("t3_idle_pc", 32'(pc1), 0);
    q1.push_back('{pc: 4'd0, sel: 4'd3, cnt: 16'd0});
    step_pulse1();
    repeat (9) @(negedge clk);
    chk("t3_step1_pc", 32'(pc1), 1);
    chk("t3_step1_halted", 32'(halted1), 1);
    q1.push_back('{pc: 4'd1, sel: 4'd3, cnt: 16'd1});
    step_pulse1();
    repeat (9) @(negedge clk);
    chk("t3_step2_pc", 32'(pc1), 2);
    chk("t3_step2_cnt", 32'(cnt1), 2);
    chk("t3_step2_halted", 32'(halted1), 1);
    q1.push_back('{pc: 4'd2, sel: 4'd3, cnt: 16'd2});
    q1.push_back('{pc: 4'd3, sel: 4'd3, cnt: 16'd3});
    step_pulse1();
    @(negedge clk);
    step_pulse1();  // lands in DECODE: must be held until HALT
    repeat (16) @(negedge clk);
    chk("t3_held_step_pc", 32'(pc1), 4);
    chk("t3_held_step_halted", 32'(halted1), 1);

    // Test 4: run drops during EXECUTE
    rst1 = 1'b0;
    fill_rom1(8'h14);
    q1.push_back('{pc: 4'd0, sel: 4'd4, cnt: 16'd0});
    repeat (2) @(negedge clk);
    run1 = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (st1 == 3'd3) break;
    end
    chk("t4_reach_exec", 32'(st1), 3);
    run1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_halted", 32'(halted1), 1);
    chk("t4_pc", 32'(pc1), 1);
    chk("t4_cnt", 32'(cnt1), 1);

    // Test 5: PRESCALE=3 pacing, then reset inside WRITEBACK before its tick
    chk("t5_rst_state", 32'(st2), 0);
    q2.push_back('{pc: 4'd0, sel: 4'd1, cnt: 16'd0});
    run2 = 1'b1;
    rst2 = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      logic [2:0] s;
      @(negedge clk);
      s = (k <= 2) ? 3'd0 : 3'((((k - 3) / 3) % 4) + 1);
      chk("t5_state", 32'(st2), 32'(s));
      chk("t5_strobes", 32'({rd2, alu2, wr2}),
          32'(((k % 3) == 2) ? strobes_for(s) : 3'b000));
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (st2 == 3'd4 && pc2 == 4'd1) break;
    end
    chk("t5_reach_wb", 32'({st2, pc2}), 32'({3'd4, 4'd1}));
    rst2 = 1'b0;
    @(negedge clk);
    chk("t5_rst_state_after", 32'(st2), 0);
    chk("t5_rst_pc", 32'(pc2), 0);
    chk("t5_rst_cnt", 32'(cnt2), 0);
    chk("t5_rst_halted", 32'(halted2), 1);
    repeat (4) @(negedge clk);
    chk("t5_no_wr", 32'(wr2), 0);

    chk("dut1_queue_empty", 32'(q1.size()), 0);
    chk("dut2_queue_empty", 32'(q2.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the tiny CPU core. It replaces the divided-clock, single-cycle execution with one clock domain and a prescaler-generated enable tick. Each instruction runs as FETCH, DECODE, EXECUTE, WRITEBACK, and the sequencer drives the ROM address, the instruction register and the register-file/ALU strobes. It also provides run, halt and single-step control, and a retired-instruction counter for the LED and debug logic.

## Interface
- PC_W, 4: program counter / ROM address width; PC wraps at 2^PC_W.
- PRESCALE, 1048576: CLK cycles per tick; legal range 1..2^24.
- CNT_W, 16: retired-instruction counter width.

- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- run  in  1  level; 1 = free-run, 0 = stop at next instruction boundary.
- step  in  1  single-CLK pulse; requests execution of exactly one instruction while halted.
- rom_data  in  8  instruction at rom_addr (asynchronous ROM read); [7:4] opcode, [3:0] register select.
- rom_addr  out  PC_W  equals pc at all times.
- pc  out  PC_W  program counter.
- opcode  out  4  ir[7:4].
- rf_sel  out  4  ir[3:0].
- rf_rd_en  out  1  one-CLK register read strobe.
- alu_en  out  1  one-CLK ALU strobe.
- rf_wr_en  out  1  one-CLK register write strobe.
- halted  out  1  1 while in HALT state.
- state  out  3  encoded state: HALT=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4.
- instr_count  out  CNT_W  retired instructions.

## Operation
- Prescaler
  - Counter counts 0..PRESCALE-1 and wraps.
  - tick=1 on the cycle where the counter equals PRESCALE-1.
  - PRESCALE=1 gives tick=1 on every cycle.
  - Free-runs in all states, including HALT.
- State transitions happen only on tick cycles; states hold otherwise.
- All strobes are qualified by tick: each fires for exactly one CLK cycle per instruction.
- HALT
  - Goes to FETCH on tick if (run=1 and stop_flag=0) or step_pend=1.
  - Taking a step clears step_pend and sets one_shot.
- FETCH: on tick, ir <= rom_data; go to DECODE.
- DECODE
  - On tick, rf_rd_en=1.
  - Opcode 0001..1000 (ALU ops): go to EXECUTE.
  - Opcode 1111 (HLT): set stop_flag; pc <= pc+1; count retires; go to HALT.
  - Opcode 0000 and 1001..1110 (NOP/reserved): pc <= pc+1; count retires; go to FETCH, or to HALT if boundary-stop applies.
- EXECUTE: on tick, alu_en=1; go to WRITEBACK.
- WRITEBACK
  - On tick, rf_wr_en=1; pc <= pc+1; instr_count <= instr_count+1.
  - Next state is FETCH, or HALT if boundary-stop applies.
- Boundary-stop: taken if run=0 or one_shot=1 at the retiring tick; clears one_shot.
- Flags
  - stop_flag clears whenever run=0.
  - step_pend is set by a step pulse in any state and is consumed only from HALT.
  - A step received mid-instruction is therefore held until the sequencer halts.
- Wrap rules: pc wraps 2^PC_W-1 -> 0; instr_count wraps to 0.
- run dropping mid-instruction does not abort: the current instruction completes, then the sequencer halts.

## Timing
- Reset values: state=HALT, halted=1, pc=0, rom_addr=0, ir=0 (opcode=0, rf_sel=0), all strobes 0, instr_count=0, prescaler=0, stop_flag=0, step_pend=0, one_shot=0.
- First tick: PRESCALE cycles after RST_N is sampled high.
- ALU instruction latency: 4 ticks HALT-exclusive, i.e. FETCH, DECODE, EXECUTE, WRITEBACK.
- NOP/HLT latency: 2 ticks.
- Leaving HALT adds 1 tick.
- With PRESCALE=1, run=1 and back-to-back ALU ops, rf_wr_en pulses every 4th CLK.
- Strobes and state change are in the same cycle: rf_wr_en is high on the WRITEBACK tick cycle, and pc updates at the end of that cycle.
- Reset takes priority over everything: asserting RST_N=0 mid-instruction returns all state to reset values on the next edge, with no strobe in that cycle.
- step and run=1 at the same tick in HALT: one transition to FETCH; step_pend is consumed.

## Test plan
- Reset / run: PRESCALE=1, run=1 from reset, ROM all 8'h11 -> state goes 0,1,2,3,4,1..., rf_wr_en high every 4th cycle with rf_sel=1, pc 0->1 at the first WRITEBACK, instr_count=16 after 64+1 cycles, pc back at 0.
- Prescaler: PRESCALE=3, run=1 -> every state held 3 CLK cycles; each strobe is exactly 1 CLK wide.
- HLT: ROM[2]=8'hF0, others 8'h12, run=1 -> halts after 3 retires with pc=3, halted=1 and no further strobes. Then run 0->1 -> resumes at pc=3.
- Single step: run=0, two step pulses 10 cycles apart -> exactly one instruction per pulse, pc 0->1->2, halted=1 between steps.
- Stop mid-instruction: run drops during EXECUTE -> WRITEBACK still fires once, then HALT with pc incremented.
- Reset mid-instruction: RST_N=0 during WRITEBACK before the tick -> no rf_wr_en; pc=0, state=HALT, instr_count=0.
